// File: rtl/fifo_rd_stream.sv
// Read-side controller that drains a 1-cycle-latency synchronous FIFO into a
// valid/ready stream through a 2-entry skid buffer, counting delivered words.
module fifo_rd_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] delivered_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e             state, state_next;
  logic             inflight;
  logic [WIDTH-1:0] buf0, buf1;
  logic [WIDTH-1:0] buf0_next, buf1_next;
  logic             pop;
  logic [1:0]       occ_cnt;
  logic [2:0]       fill;
  logic [1:0]       wr_slot;

  assign m_valid = (state != EMPTY);
  assign m_data  = buf0;
  assign busy    = m_valid || inflight;
  assign pop     = m_valid && m_ready;

  always_comb begin
    occ_cnt    = 2'd0;
    fill       = 3'd0;
    wr_slot    = 2'd0;
    state_next = state;
    buf0_next  = buf0;
    buf1_next  = buf1;
    fifo_rd_en = 1'b0;

    unique case (state)
      EMPTY:   occ_cnt = 2'd0;
      ONE:     occ_cnt = 2'd1;
      TWO:     occ_cnt = 2'd2;
      default: occ_cnt = 2'd0;
    endcase

    // Occupancy after this edge, counting the word already in flight.
    fill = {1'b0, occ_cnt} + {2'b00, inflight} - {2'b00, pop};

    fifo_rd_en = rst && en && !fifo_empty && (fill < 3'd2);

    unique case (fill)
      3'd0:    state_next = EMPTY;
      3'd1:    state_next = ONE;
      default: state_next = TWO;
    endcase

    // Pop shifts the tail to the head; a landing word goes to the first free
    // slot after that shift, so capture and pop can coincide in any state.
    if (pop) begin
      buf0_next = buf1;
    end
    wr_slot = occ_cnt - {1'b0, pop};
    if (inflight) begin
      if (wr_slot == 2'd0) begin
        buf0_next = fifo_data;
      end else begin
        buf1_next = fifo_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= EMPTY;
      inflight      <= 1'b0;
      buf0          <= '0;
      buf1          <= '0;
      delivered_cnt <= '0;
    end else begin
      state    <= state_next;
      inflight <= fifo_rd_en;
      buf0     <= buf0_next;
      buf1     <= buf1_next;
      if (pop) begin
        delivered_cnt <= delivered_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side controller for the team's synchronous FIFO. It drains the FIFO through its rd_en/empty/data_out interface and presents the words as a valid/ready stream to a downstream consumer. The FIFO has a 1-cycle registered read latency, so the block tracks in-flight reads. Reads land in a 2-entry output buffer so the stream sustains 1 word/cycle under backpressure without losing data. It sits between fifo_if's read side and any streaming sink.

Parameters:
WIDTH, 8, data word width (matches FIFO WIDTH)
CNT_W, 16, width of delivered-word counter

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset
en  in  1  1 = allow new FIFO reads; 0 = stop issuing reads (in-flight read still captured)
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  FIFO read strobe
fifo_data  in  WIDTH  FIFO data_out; valid the cycle after fifo_rd_en=1
m_valid  out  1  output word valid
m_ready  in  1  downstream ready
m_data  out  WIDTH  output word (head of buffer)
delivered_cnt  out  CNT_W  count of completed m_valid&&m_ready transfers; wraps modulo 2^CNT_W
busy  out  1  occ!=0 or inflight=1

Behaviour:
- Reset (rst=0, async): occ=0, inflight=0, delivered_cnt=0, m_valid=0, m_data=0, busy=0, buffer contents cleared. fifo_rd_en forced to 0 combinationally while rst=0.
- State:
  - occ in {0,1,2}: buffer occupancy; states EMPTY/ONE/TWO.
  - inflight in {0,1}: registered copy of fifo_rd_en.
- pop = m_valid && m_ready.
- fifo_rd_en (combinational) = rst && en && !fifo_empty && (occ + inflight - pop) < 2. Depends combinationally on m_ready; this is intended.
- Capture: when inflight=1, fifo_data is written into the buffer at that posedge. Buffer is FIFO-ordered, head at m_data.
- Occupancy: occ_next = occ + inflight - pop. Simultaneous capture and pop allowed in every state.
  - Capture in TWO without pop is impossible by construction.
  - Verification asserts occ never exceeds 2.
- m_valid = (occ != 0), registered-state derived. m_data stable while m_valid=1 and m_ready=0.
- Latency: FIFO non-empty with occ=0, inflight=0, en=1 at cycle t
  - fifo_rd_en=1 in t
  - word captured at posedge ending t+1
  - m_valid=1 in t+2 (2-cycle fill latency)
- Throughput: with m_ready held 1 and FIFO never empty, one read and one transfer every cycle after fill.
- Backpressure: m_ready=0 lets the buffer fill to TWO, then fifo_rd_en stays 0. No word is dropped or duplicated.
- en=0: no new reads. A pending in-flight word is still captured. Buffered words still drain.
- fifo_empty=1: no read regardless of buffer space. fifo_empty is sampled only in the cycle fifo_rd_en would assert.
- delivered_cnt increments by 1 on each pop and wraps 2^CNT_W-1 -> 0.
- Reset mid-operation: in-flight and buffered words are discarded, and all outputs return to reset values immediately. The FIFO's own reset is the system's responsibility.
- Ordering: m_data sequence equals FIFO read order exactly.

Test Plan:
- Reset then idle: FIFO empty, en=1, m_ready=1 -> fifo_rd_en=0, m_valid=0, delivered_cnt=0 for 20 cycles.
- Single word: FIFO holds 0xA5 from cycle 0, m_ready=1 ->
  - fifo_rd_en=1 in cycle 0 only
  - m_valid=1 with m_data=0xA5 in cycle 2 only
  - delivered_cnt=1 afterwards
- Streaming: FIFO preloaded with 0x01..0x08, m_ready=1 ->
  - fifo_rd_en high cycles 0-7
  - m_data=0x01..0x08 in cycles 2-9, back-to-back
  - delivered_cnt=8, busy=0 at cycle 10
- Backpressure: preload 0x10..0x14, m_ready=0 for cycles 0-9, then 1 ->
  - exactly 2 reads issued before cycle 10
  - m_data holds 0x10 through cycle 9
  - then 0x10..0x14 delivered in order, no loss or duplication
- en toggle: preload 6 words, en=0 from cycle 1 ->
  - exactly 1 read
  - one word delivered
  - re-assert en -> remaining 5 words delivered in order
- Reset mid-stream + wrap: CNT_W=4, deliver 17 words -> delivered_cnt=1. Then assert rst with occ=2 -> m_valid=0, delivered_cnt=0, fifo_rd_en=0 in the same cycle.
